// File: rtl/ntt_pkg.sv
// Shared NTT pipeline constants, sizing helpers and the fifo2 address type
// used by the fifo address sequencer.
package ntt_pkg;

  localparam int unsigned NTT_STAGE_CNT = 8;
  localparam int unsigned MUL_STAGE_CNT = 4;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Stages 0..n-2 halve in depth from 1<<(n-2); the final stage is depth 1.
  function automatic int unsigned stage_depth(input int unsigned i,
                                              input int unsigned n = NTT_STAGE_CNT);
    return (i + 1 >= n) ? 32'd1 : (32'd1 << (n - 2 - i));
  endfunction

  localparam int unsigned MAX_HRS = 32'd1 << (NTT_STAGE_CNT - 2);
  localparam int unsigned AW      = $clog2(max(MAX_HRS, MUL_STAGE_CNT));
  localparam int unsigned MW      = $clog2(MUL_STAGE_CNT - 1);

  typedef logic [AW-1:0] fifo2_addr_t;

endpackage

// File: rtl/stage_addr_cnt.sv
// Circular address counter for one NTT stage delay line: address, butterfly
// half-select and a one-cycle wrap pulse.
module stage_addr_cnt
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] addr_o,
  output logic         sel_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] addr_q, addr_d;
  logic         sel_q, sel_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      addr_d = '0;
      sel_d  = 1'b0;
    end else if (en_i) begin
      if (addr_q == LAST) begin
        addr_d = '0;
        sel_d  = ~sel_q;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      sel_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o = addr_q;
  assign sel_o  = sel_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/fifo_addr_ctrl.sv
// Shared address sequencer for the NTT/INTT fifo controllers: one circular
// counter per stage delay line plus the multiplier FIFO counter.
module fifo_addr_ctrl #(
  parameter  int unsigned NTT_STAGE_CNT = ntt_pkg::NTT_STAGE_CNT,
  parameter  int unsigned MUL_STAGE_CNT = ntt_pkg::MUL_STAGE_CNT,
  localparam int unsigned MAX_HRS       = 32'd1 << (NTT_STAGE_CNT - 2),
  localparam int unsigned AW            = $clog2(ntt_pkg::max(MAX_HRS, MUL_STAGE_CNT)),
  localparam int unsigned MW            = $clog2(MUL_STAGE_CNT - 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic [NTT_STAGE_CNT-1:0]          en,
  input  logic                              fifom_en,
  output logic [NTT_STAGE_CNT-1:0][AW-1:0]  fifo2_addr,
  output logic [NTT_STAGE_CNT-1:0]          fifo2_sel,
  output logic [NTT_STAGE_CNT-1:0]          fifo2_wrap,
  output logic [MW-1:0]                     fifom_addr,
  output logic                              idle
);

  localparam logic [MW-1:0] FM_LAST = MW'(MUL_STAGE_CNT - 2);

  logic [MW-1:0] fifom_q, fifom_d;

  for (genvar gi = 0; gi < NTT_STAGE_CNT; gi++) begin : g_stage
    stage_addr_cnt #(
      .DEPTH(ntt_pkg::stage_depth(gi, NTT_STAGE_CNT)),
      .W    (AW)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .en_i  (en[gi]),
      .addr_o(fifo2_addr[gi]),
      .sel_o (fifo2_sel[gi]),
      .wrap_o(fifo2_wrap[gi])
    );
  end

  always_comb begin
    fifom_d = fifom_q;
    if (clr) begin
      fifom_d = '0;
    end else if (fifom_en) begin
      fifom_d = (fifom_q == FM_LAST) ? '0 : fifom_q + MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifom_q <= '0;
    end else begin
      fifom_q <= fifom_d;
    end
  end

  assign fifom_addr = fifom_q;
  assign idle       = (fifo2_addr == '0) && (fifo2_sel == '0) && (fifom_q == '0);

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Scoreboard bench for fifo_addr_ctrl: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_fifo_addr_ctrl;

  localparam int K_STAGE = 0;
  localparam int K_FIFOM = 1;
  localparam int K_IDLE  = 2;

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic [7:0]          en;
  logic                fifom_en;
  logic [7:0][5:0]     fifo2_addr;
  logic [7:0]          fifo2_sel;
  logic [7:0]          fifo2_wrap;
  logic [1:0]          fifom_addr;
  logic                idle;

  fifo_addr_ctrl #(
    .NTT_STAGE_CNT(8),
    .MUL_STAGE_CNT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .fifom_en  (fifom_en),
    .fifo2_addr(fifo2_addr),
    .fifo2_sel (fifo2_sel),
    .fifo2_wrap(fifo2_wrap),
    .fifom_addr(fifom_addr),
    .idle      (idle)
  );

  typedef struct {
    int         cyc;
    int         kind;
    int         s;
    logic [5:0] a;
    logic       sel;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   depth_tab[8] = '{64, 32, 16, 8, 4, 2, 1, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: check for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
      end else if (e.kind == K_STAGE) begin
        if (fifo2_addr[e.s] !== e.a || fifo2_sel[e.s] !== e.sel || fifo2_wrap[e.s] !== e.wrap) begin
          n_bad++;
          $display("FAIL %s stage%0d cyc%0d: got addr=%0d sel=%b wrap=%b, expected addr=%0d sel=%b wrap=%b",
                   e.name, e.s, cyc, fifo2_addr[e.s], fifo2_sel[e.s], fifo2_wrap[e.s],
                   e.a, e.sel, e.wrap);
        end
      end else if (e.kind == K_FIFOM) begin
        if (fifom_addr !== e.a[1:0]) begin
          n_bad++;
          $display("FAIL %s cyc%0d: got fifom_addr=%0d, expected %0d", e.name, cyc, fifom_addr, e.a[1:0]);
        end
      end else begin
        if (idle !== e.sel) begin
          n_bad++;
          $display("FAIL %s cyc%0d: got idle=%b, expected %b", e.name, cyc, idle, e.sel);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic c, input logic [7:0] e, input logic f);
    @(posedge clk);
    #1;
    rst_n    = r;
    clr      = c;
    en       = e;
    fifom_en = f;
  endtask

  task automatic exp_stage(input string nm, input int s, input int a, input logic sl, input logic w);
    exp_t e;
    e.cyc = cyc + 1; e.kind = K_STAGE; e.s = s; e.a = 6'(a); e.sel = sl; e.wrap = w; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_fifom(input string nm, input int a);
    exp_t e;
    e.cyc = cyc + 1; e.kind = K_FIFOM; e.s = 0; e.a = 6'(a); e.sel = 1'b0; e.wrap = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input string nm, input logic v);
    exp_t e;
    e.cyc = cyc + 1; e.kind = K_IDLE; e.s = 0; e.a = '0; e.sel = v; e.wrap = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_all_zero(input string nm);
    for (int i = 0; i < 8; i++) exp_stage(nm, i, 0, 1'b0, 1'b0);
    exp_fifom(nm, 0);
    exp_idle(nm, 1'b1);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; clr = 1'b0; en = '0; fifom_en = 1'b0;

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    exp_all_zero("reset");
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    exp_idle("idle_after_reset", 1'b1);

    for (int k = 1; k <= 64; k++) begin
      drive(1'b1, 1'b0, 8'h01, 1'b0);
      exp_stage("s0_count", 0, k % 64, k == 64, k == 64);
      exp_stage("s1_quiet", 1, 0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    exp_stage("s0_hold", 0, 0, 1'b1, 1'b0);
    exp_idle("idle_sel_set", 1'b0);

    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 8'hC0, 1'b0);
      exp_stage("s6_d1", 6, 0, k % 2 == 1, 1'b1);
      exp_stage("s7_d1", 7, 0, k % 2 == 1, 1'b1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    exp_stage("s7_hold", 7, 0, 1'b0, 1'b0);

    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      exp_fifom("fifom_count", k % 3);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    exp_fifom("fifom_hold", 1);

    for (int p = 1; p <= 32; p++) begin
      drive(1'b1, 1'b0, 8'h02, 1'b0);
      exp_stage("s1_pulse", 1, p % 32, p == 32, p == 32);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      exp_stage("s1_gap", 1, p % 32, p == 32, 1'b0);
    end

    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 1'b0, 8'h01, 1'b0);
      if (k == 17) exp_stage("s0_to17", 0, 17, 1'b1, 1'b0);
    end
    drive(1'b1, 1'b1, 8'h01, 1'b1);
    exp_all_zero("clr");
    drive(1'b1, 1'b0, 8'h01, 1'b0);
    exp_stage("post_clr", 0, 1, 1'b0, 1'b0);
    exp_idle("post_clr_idle", 1'b0);

    drive(1'b0, 1'b0, 8'hFF, 1'b1);
    exp_all_zero("rst_beats_en");
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 1'b0, 8'hFF, 1'b1);
      for (int i = 0; i < 8; i++)
        exp_stage("resume", i, k % depth_tab[i], ((k / depth_tab[i]) % 2) == 1,
                  (k % depth_tab[i]) == 0);
      exp_fifom("resume_fifom", k % 3);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_addr_ctrl.md
Name: fifo_addr_ctrl

Overview:
Shared address sequencer behind the NTT/INTT fifo controller interface: it drives the counter side of that interface. It holds one circular write/read address counter per NTT stage delay-line FIFO, plus one counter for the multiplier-stage FIFO. Each counter advances on the merged per-stage enable from all NTT/INTT clients. Per stage it also produces the butterfly half-select and a wrap pulse, so every client pipeline shares one set of counters instead of duplicating them.

Parameters:
NTT_STAGE_CNT, 8, number of NTT pipeline stages.
MUL_STAGE_CNT, 4, multiplier pipeline depth; the fifom counter runs modulo MUL_STAGE_CNT-1.
MAX_HRS, 1<<(NTT_STAGE_CNT-2), depth of the stage-0 delay line (derived, not overridable).
AW, $clog2(max(MAX_HRS,MUL_STAGE_CNT)), width of each fifo2 address (derived).
MW, $clog2(MUL_STAGE_CNT-1), width of the fifom address (derived).

Ports:
clk  in  1  clock, all logic on the rising edge
rst_n  in  1  synchronous active-low reset
clr  in  1  synchronous soft clear of all counters, for flush between polynomials
en  in  NTT_STAGE_CNT  merged per-stage advance request (OR of all clients, stage-indexed)
fifom_en  in  1  advance request for the multiplier FIFO counter
fifo2_addr  out  NTT_STAGE_CNT x AW  per-stage delay-line address
fifo2_sel  out  NTT_STAGE_CNT  per-stage half-select: 0 = fill FIFO, 1 = butterfly with FIFO output
fifo2_wrap  out  NTT_STAGE_CNT  one-cycle pulse: stage address just wrapped to 0
fifom_addr  out  MW  multiplier FIFO address
idle  out  1  all addresses 0 and all sel 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at an edge): fifo2_addr=0, fifo2_sel=0, fifo2_wrap=0, fifom_addr=0. idle reads 1 in the following cycle.
- Stage depth D_i = 1<<(NTT_STAGE_CNT-2-i) for i in 0..NTT_STAGE_CNT-2. Last stage: D_i = 1.
- All outputs are registered except idle, which is combinational from the registers.
- Stage i, edge with en[i]=1:
  - if addr==D_i-1: addr<=0, sel<=~sel, wrap<=1;
  - else: addr<=addr+1, wrap<=0.
- Stage i, edge with en[i]=0: addr and sel hold, wrap<=0.
- Effect: the address changes one cycle after the enable cycle; wrap is high for exactly the one cycle after the wrapping enable.
- D_i=1: addr is constant 0; every enable toggles sel and pulses wrap.
- Back-to-back enables give one increment per cycle; there is no stall and no skip.
- Upper address bits above log2(D_i) are always 0. A bench check must flag any nonzero value.
- fifom_addr: on fifom_en=1 it increments modulo MUL_STAGE_CNT-1 (wraps from MUL_STAGE_CNT-2 to 0); otherwise it holds.
- Priority: rst_n=0 beats clr, and clr beats en/fifom_en. clr=1 forces addr, sel and fifom_addr to 0 and wrap to 0, same as reset.
- Reset or clr mid-sequence discards partial progress. The next enable produces addr=1, sel=0.
- Stages are fully independent. Simultaneous enables on any subset of stages all take effect in the same cycle.
- No handshake back to clients. en is a single-cycle qualifier with no backpressure.

Decomposition:
- Shared package ntt_pkg holds:
  - the NTT_STAGE_CNT and MUL_STAGE_CNT constants;
  - a max() function;
  - a stage_depth(i) function;
  - the AW/MW localparams;
  - typedef fifo2_addr_t = logic [AW-1:0].
- One sub-module, stage_addr_cnt (parameter DEPTH). It holds the addr/sel/wrap registers for one stage and is instantiated NTT_STAGE_CNT times in a generate loop.
- The fifom counter stays inline in fifo_addr_ctrl.

Test Plan:
- Reset then 64 consecutive en[0] cycles (defaults: D_0=64, AW=6) -> fifo2_addr[0] goes 1..63 then 0; wrap[0]=1 on exactly the cycle addr returns to 0; sel[0] goes 0->1.
- en[6] and en[7] held 1 for 4 cycles (D=1) -> addr stays 0; sel toggles 1,0,1,0; wrap=1 all 4 cycles.
- fifom_en held 1 for 7 cycles (MUL_STAGE_CNT=4, modulo 3) -> fifom_addr 1,2,0,1,2,0,1.
- en[1] pulsed every other cycle, 32 pulses (D_1=32) -> addr advances only on pulsed cycles; single wrap after the 32nd pulse; no upper-bit activity (bit5 stays 0).
- Drive addr[0]=17, then clr=1 together with en[0]=1 -> next cycle addr[0]=0, sel=0, wrap=0, idle=1; then one en gives addr=1.
- rst_n=0 together with clr=0 and all en=1 -> all outputs 0 next cycle; release reset -> normal counting resumes from 0 on all stages simultaneously.
